// File: rtl/coco_ioctl_upload.sv
// coco_ioctl_upload
// Answers HPS ioctl upload reads for one menu index by fetching bytes from a
// shared 8-bit memory port through a request/acknowledge arbiter. hps_io is
// stalled with ioctl_wait while a fetch is outstanding. Addresses at or above
// SIZE, and fetches that exceed TIMEOUT cycles, return 8'hFF.
module coco_ioctl_upload #(
    parameter logic [7:0] INDEX   = 8'd2,
    parameter int         ADDR_W  = 15,
    parameter int         SIZE    = 32768,
    parameter int         BASE    = 0,
    parameter int         TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              upload_done,
    output logic [24:0]       byte_count,
    output logic              timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // One bit wider than ioctl_addr so SIZE up to 2^25 compares correctly.
    localparam logic [25:0]       SIZE_L   = 26'(SIZE);
    localparam logic [ADDR_W-1:0] BASE_L   = ADDR_W'(BASE);
    // Last counter value before the wait is given up.
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_r, state_s;
    logic                active_s, active_r;
    logic                start_s, req_s, in_range_s;
    logic                wait_s;
    logic [7:0]          din_r, din_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                mem_rd_r, mem_rd_s;
    logic [7:0]          tcnt_r, tcnt_s;
    logic [24:0]         cnt_r, cnt_s, cnt_base_s;
    logic                err_r, err_s, err_base_s;
    logic                busy_r, done_r;

    assign active_s   = ioctl_upload & (ioctl_index == INDEX);
    assign start_s    = active_s & ~active_r;
    assign req_s      = ioctl_rd & active_s;
    assign in_range_s = ({1'b0, ioctl_addr} < SIZE_L);

    assign ioctl_din   = din_r;
    assign ioctl_wait  = wait_s;
    assign mem_addr    = mem_addr_r;
    assign mem_rd      = mem_rd_r;
    assign busy        = busy_r;
    assign upload_done = done_r;
    assign byte_count  = cnt_r;
    assign timeout_err = err_r;

    // Next-state and next-register values; the stall output is combinational
    // so hps_io sees it in the same cycle as its ioctl_rd strobe.
    always_comb begin
        state_s    = state_r;
        din_s      = din_r;
        mem_addr_s = mem_addr_r;
        mem_rd_s   = mem_rd_r;
        tcnt_s     = tcnt_r;
        wait_s     = 1'b0;
        cnt_base_s = start_s ? 25'd0 : cnt_r;
        err_base_s = start_s ? 1'b0 : err_r;
        cnt_s      = cnt_base_s;
        err_s      = err_base_s;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (in_range_s) begin
                        wait_s     = 1'b1;
                        mem_addr_s = BASE_L + ioctl_addr[ADDR_W-1:0];
                        mem_rd_s   = 1'b1;
                        tcnt_s     = 8'd0;
                        state_s    = ST_FETCH;
                    end else begin
                        din_s = 8'hFF;
                        cnt_s = cnt_base_s + 25'd1;
                    end
                end else begin
                    wait_s = 1'b0;
                end
            end
            ST_FETCH: begin
                wait_s = 1'b1;
                if (!active_s) begin
                    // Session ended under us: drop the request, keep old data.
                    mem_rd_s = 1'b0;
                    state_s  = ST_IDLE;
                end else if (mem_ack) begin
                    din_s    = mem_data;
                    mem_rd_s = 1'b0;
                    cnt_s    = cnt_base_s + 25'd1;
                    state_s  = ST_IDLE;
                end else if (tcnt_r == TMO_LAST) begin
                    din_s    = 8'hFF;
                    err_s    = 1'b1;
                    mem_rd_s = 1'b0;
                    cnt_s    = cnt_base_s + 25'd1;
                    state_s  = ST_IDLE;
                end else begin
                    tcnt_s = tcnt_r + 8'd1;
                end
            end
            default: begin
                mem_rd_s = 1'b0;
                state_s  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            active_r   <= 1'b0;
            din_r      <= 8'hFF;
            mem_addr_r <= '0;
            mem_rd_r   <= 1'b0;
            tcnt_r     <= 8'd0;
            cnt_r      <= 25'd0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            active_r   <= active_s;
            din_r      <= din_s;
            mem_addr_r <= mem_addr_s;
            mem_rd_r   <= mem_rd_s;
            tcnt_r     <= tcnt_s;
            cnt_r      <= cnt_s;
            err_r      <= err_s;
            busy_r     <= (state_s == ST_FETCH);
            done_r     <= active_r & ~active_s;
        end
    end

endmodule

// File: tb/tb_coco_ioctl_upload.sv
// Bench for coco_ioctl_upload: directed corner cases plus randomized reads.
// Expected bytes come from a memory image and the read rules; a monitor pops
// them whenever byte_count advances.
module tb_coco_ioctl_upload;

    localparam int SIZE = 32768;
    localparam int TMO  = 4;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        busy;
    logic        upload_done;
    logic [24:0] byte_count;
    logic        timeout_err;

    always #5 clk_sys = ~clk_sys;

    coco_ioctl_upload #(
        .INDEX(8'd2), .ADDR_W(15), .SIZE(SIZE), .BASE(0), .TIMEOUT(TMO)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy),
        .upload_done(upload_done), .byte_count(byte_count), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [7:0]  din;
        logic [24:0] cnt;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [7:0]  mem_model [0:SIZE-1];
    logic [7:0]  m_din;
    logic [24:0] m_cnt;
    logic        m_err;
    logic [24:0] prev_cnt;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Monitor: each new byte_count value marks a byte handed to hps_io.
    initial begin
        prev_cnt = 25'd0;
        forever begin
            @(negedge clk_sys);
            if (reset || !mon_en) begin
                prev_cnt = byte_count;
            end else if (byte_count !== prev_cnt) begin
                prev_cnt = byte_count;
                if (byte_count != 25'd0) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got count %0h expected none", byte_count);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("mon_din", {24'd0, ioctl_din}, {24'd0, mon_e.din});
                        chk("mon_count", {7'd0, byte_count}, {7'd0, mon_e.cnt});
                        chk("mon_err", {31'd0, timeout_err}, {31'd0, mon_e.err});
                    end
                end
            end
        end
    end

    // One hps_io read; lat = FETCH cycle index carrying the ack, >= TMO for none.
    task automatic do_read(input logic [24:0] addr, input int lat);
        bit   inr   = (addr < SIZE);
        bit   to    = (lat >= TMO);
        int   stall = 0;
        int   exp_stall;
        exp_t e;
        m_cnt = m_cnt + 25'd1;
        if (!inr) m_din = 8'hFF;
        else if (to) begin m_din = 8'hFF; m_err = 1'b1; end
        else m_din = mem_model[addr[14:0]];
        e.din = m_din; e.cnt = m_cnt; e.err = m_err;
        sbq.push_back(e);
        exp_stall = !inr ? 0 : (to ? TMO + 1 : lat + 2);

        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        #1;
        chk("wait_on_rd", {31'd0, ioctl_wait}, {31'd0, inr});
        if (ioctl_wait === 1'b1) stall++;
        tick();
        ioctl_rd   = 1'b0;
        ioctl_addr = 25'($urandom);
        if (inr) begin
            chk("mem_rd_set", {31'd0, mem_rd}, 32'd1);
            chk("mem_addr", {17'd0, mem_addr}, {17'd0, addr[14:0]});
            chk("busy_set", {31'd0, busy}, 32'd1);
            for (int k = 0; k < 20; k++) begin
                mem_ack  = (k == lat);
                mem_data = mem_ack ? mem_model[mem_addr] : 8'($urandom);
                #1;
                if (ioctl_wait !== 1'b1) break;
                stall++;
                tick();
                mem_ack = 1'b0;
            end
            chk("mem_rd_clr", {31'd0, mem_rd}, 32'd0);
        end else begin
            #1;
            chk("oor_no_mem_rd", {31'd0, mem_rd}, 32'd0);
        end
        chk("stall_cycles", stall, exp_stall);
    endtask

    task automatic count_done(input int n, output int p);
        p = 0;
        repeat (n) begin
            tick();
            if (upload_done === 1'b1) p++;
        end
    endtask

    task automatic start_session(input logic [7:0] idx);
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        tick();
        tick();
        if (idx == 8'd2) begin
            m_cnt = 25'd0;
            m_err = 1'b0;
        end
    endtask

    int         pulses;
    int         r;
    logic [24:0] a;

    initial begin
        for (int i = 0; i < SIZE; i++) mem_model[i] = 8'($urandom);
        mem_model[16] = 8'h5A;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        ioctl_addr = 25'd0; mem_ack = 1'b0; mem_data = 8'd0;
        m_din = 8'hFF; m_cnt = 25'd0; m_err = 1'b0;
        repeat (3) tick();
        chk("rst_din", {24'd0, ioctl_din}, 32'h0000_00FF);
        chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, upload_done}, 32'd0);
        chk("rst_count", {7'd0, byte_count}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Session 1: directed corners, then random traffic.
        start_session(8'd2);
        do_read(25'h0010, 3);
        do_read(25'd32768, 0);
        do_read(25'd0, 0);
        do_read(25'd32767, 1);
        do_read(25'd100, TMO);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        mem_ack = 1'b1; mem_data = 8'h00;
        tick();
        tick();
        mem_ack = 1'b0;
        chk("late_ack_din", {24'd0, ioctl_din}, 32'h0000_00FF);
        chk("late_ack_count", {7'd0, byte_count}, {7'd0, m_cnt});
        chk("late_ack_mem_rd", {31'd0, mem_rd}, 32'd0);
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70) a = 25'($urandom_range(0, SIZE - 1));
            else if (r < 85) a = 25'($urandom_range(SIZE, 33554431));
            else begin
                case ($urandom_range(0, 2))
                    0: a = 25'd0;
                    1: a = 25'd32767;
                    default: a = 25'd32768;
                endcase
            end
            do_read(a, $urandom_range(0, 5));
            repeat ($urandom_range(0, 2)) tick();
        end
        ioctl_upload = 1'b0;
        count_done(4, pulses);
        chk("done_end_session", pulses, 1);

        // Session 2: sticky error cleared, then abort mid-fetch with an ack.
        start_session(8'd2);
        chk("new_session_err", {31'd0, timeout_err}, 32'd0);
        chk("new_session_count", {7'd0, byte_count}, 32'd0);
        ioctl_addr = 25'd5; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        ioctl_upload = 1'b0; mem_ack = 1'b1; mem_data = 8'h33;
        tick();
        mem_ack = 1'b0;
        chk("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("abort_din", {24'd0, ioctl_din}, {24'd0, m_din});
        chk("abort_count", {7'd0, byte_count}, {7'd0, m_cnt});
        chk("abort_done", {31'd0, upload_done}, 32'd1);
        count_done(3, pulses);
        chk("abort_done_once", pulses, 0);

        // Foreign index: ignored, no done pulse.
        start_session(8'd3);
        ioctl_addr = 25'd7; ioctl_rd = 1'b1;
        #1;
        chk("idx_wait", {31'd0, ioctl_wait}, 32'd0);
        tick();
        ioctl_rd = 1'b0;
        chk("idx_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("idx_din", {24'd0, ioctl_din}, {24'd0, m_din});
        chk("idx_count", {7'd0, byte_count}, {7'd0, m_cnt});
        ioctl_upload = 1'b0;
        count_done(4, pulses);
        chk("idx_no_done", pulses, 0);

        // Reset while fetching.
        start_session(8'd2);
        ioctl_addr = 25'd9; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("pre_rst_mem_rd", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rstf_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rstf_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rstf_din", {24'd0, ioctl_din}, 32'h0000_00FF);
        chk("rstf_count", {7'd0, byte_count}, 32'd0);
        chk("rstf_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        m_din = 8'hFF; m_cnt = 25'd0; m_err = 1'b0;
        tick();
        tick();
        do_read(25'd1234, 1);
        do_read(25'd40000, 0);
        repeat (3) tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coco_ioctl_upload.md
# coco_ioctl_upload

Upload responder for the HPS ioctl channel, the read-back counterpart of the ROM/cartridge download path. While the HPS runs an upload session for its menu index, the block answers each `ioctl_rd` strobe by fetching one byte from a shared 8-bit memory port (cartridge RAM / NVRAM) through a request/acknowledge arbiter. It stalls `hps_io` with `ioctl_wait` while the fetch is outstanding and presents the byte on `ioctl_din`. It sits beside `hps_io` in the `emu` top, on the `clk_sys` domain.

## Interface
Parameters:
- `INDEX`, 8'd2: `ioctl_index` value this block serves.
- `ADDR_W`, 15: width of the memory address port.
- `SIZE`, 32768: number of bytes exposed. Upload addresses at or above `SIZE` read as 8'hFF.
- `BASE`, 0: memory offset added to `ioctl_addr`.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_ack`. Range 1..255.

Ports:
- `clk_sys` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `ioctl_upload` in 1: upload session in progress (from `hps_io`).
- `ioctl_index` in 8: menu index of the session.
- `ioctl_rd` in 1: one-cycle byte request.
- `ioctl_addr` in 25: byte address of the request, valid when `ioctl_rd`=1.
- `ioctl_din` out 8: byte returned to `hps_io`.
- `ioctl_wait` out 1: stall to `hps_io`.
- `mem_addr` out ADDR_W: memory address.
- `mem_rd` out 1: read request, held high until acknowledged.
- `mem_ack` in 1: arbiter grant/data-valid strobe. Meaningful only while `mem_rd`=1.
- `mem_data` in 8: read data, valid in the `mem_ack` cycle.
- `busy` out 1: FETCH state active.
- `upload_done` out 1: one-cycle pulse when a served session ends.
- `byte_count` out 25: requests answered this session.
- `timeout_err` out 1: sticky flag, set on any timeout in the current session.

## Operation
- `active = ioctl_upload & (ioctl_index == INDEX)`. This is registered as `active_q` for edge detection.
- Session start (`active` & !`active_q`): clear `byte_count` and `timeout_err`.
- States: IDLE and FETCH.
- IDLE, `ioctl_rd` & `active` & `ioctl_addr` < `SIZE`:
  - Latch `mem_addr = (BASE + ioctl_addr[ADDR_W-1:0]) mod 2^ADDR_W`.
  - Set `mem_rd`=1, clear the timeout counter, go to FETCH.
- IDLE, `ioctl_rd` & `active` & `ioctl_addr` ≥ `SIZE`:
  - `ioctl_din` <= 8'hFF and `byte_count`++.
  - Stay in IDLE. No memory access, no wait.
- IDLE, `ioctl_rd` with `active`=0: ignored. `ioctl_din` is unchanged.
- FETCH, `mem_ack`=1:
  - `ioctl_din` <= `mem_data`, `mem_rd` <= 0, `byte_count`++.
  - Go to IDLE.
- FETCH, no ack, and the counter reaches `TIMEOUT`:
  - `ioctl_din` <= 8'hFF, `timeout_err` <= 1, `mem_rd` <= 0, `byte_count`++.
  - Go to IDLE.
- FETCH, `active` falls: abort. `mem_rd` <= 0, go to IDLE, `ioctl_din` unchanged, count unchanged.
- `mem_ack` while `mem_rd`=0 (late ack after a timeout or abort): ignored.
- `ioctl_rd` while in FETCH: ignored. This is a protocol violation; `hps_io` is stalled at that point.
- `ioctl_wait` = (IDLE & `ioctl_rd` & `active` & in-range) | FETCH. It is combinational so there is no unstalled gap.
- `upload_done` = `active_q` & !`active`, registered. It pulses even if the session ended in an abort.
- `byte_count` wraps modulo 2^25.

## Timing
- Reset values: `ioctl_din`=8'hFF, `ioctl_wait`=0, `mem_rd`=0, `mem_addr`=0, `busy`=0, `upload_done`=0, `byte_count`=0, `timeout_err`=0, state IDLE, `active_q`=0.
- Reset asserted mid-FETCH: every output returns to its reset value at the next edge.
- Fastest in-range read:
  - Cycle 0: `ioctl_rd`=1, `ioctl_wait`=1.
  - Cycle 1: `mem_rd`=1, and the ack arrives this cycle.
  - Cycle 2: `ioctl_din` is valid and `ioctl_wait`=0.
- General in-range latency: `ioctl_din` is valid one edge after the `mem_ack` cycle.
- Out-of-range read: `ioctl_din`=FF at the next edge and `ioctl_wait` stays 0.
- Timeout: the counter increments in each FETCH cycle without ack. On reaching `TIMEOUT`, FF is output at the next edge. Total stall is `TIMEOUT`+1 cycles.
- Ack and timeout in the same cycle: the ack wins.
- Abort (`active` falls) and ack in the same cycle: the abort wins and the data is discarded.
- `busy` equals FETCH, registered.

## Test plan
- Index match, addr 0x0010, ack 3 cycles after `mem_rd`, `mem_data`=0x5A -> `mem_addr`=0x0010 (BASE=0), `ioctl_wait` high for 5 cycles, `ioctl_din`=0x5A, `byte_count`=1.
- `ioctl_addr`=32768 with SIZE=32768 -> no `mem_rd`, `ioctl_wait` never high, `ioctl_din`=0xFF next cycle, `byte_count`++.
- No ack, TIMEOUT=4 -> `ioctl_din`=0xFF after 5 stall cycles, `timeout_err`=1. A later ack is ignored. Starting a new session clears `timeout_err`.
- `ioctl_index`=3 with INDEX=2, `ioctl_rd` pulsed -> no `mem_rd`, no wait, `ioctl_din` unchanged, no `upload_done` when `ioctl_upload` falls.
- `ioctl_upload` drops during FETCH -> `mem_rd` low next cycle, state IDLE, `upload_done` pulses once.
- `reset` in FETCH with `mem_rd`=1 -> next edge: `mem_rd`=0, `ioctl_wait`=0, `ioctl_din`=0xFF, `byte_count`=0.
